// File: rtl/uart_word_serdes.sv
// rtl/uart_word_serdes.sv - full-duplex 8N1 UART carrying 32-bit words plus a 2-bit selector
//
// RX deserialises 5-byte frames (control byte, then data bytes LSB first).
// TX serialises one 32-bit word as 4 back-to-back bytes per flag_tx rising edge.
//
// Ports:
//   CLK, RST_N      system clock, asynchronous active-low reset
//   RX, TX          serial lines, idle high
//   data_rx         last received word, held until the next good frame
//   controlBits     selector bits [1:0] of the last frame's control byte
//   done_rx         one-cycle strobe, data_rx/controlBits updated this cycle
//   rx_err          one-cycle strobe, partial frame discarded
//   data_tx         word to send, latched on an accepted flag_tx rising edge
//   flag_tx         transmit request level
//   done_tx         one-cycle strobe after the last stop bit of a word
module uart_word_serdes #(
   parameter int c_CLKS_PER_BIT = 434,
   parameter int c_GAP_BITS     = 20
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        RX,
   output logic        TX,
   output logic [31:0] data_rx,
   output logic [1:0]  controlBits,
   output logic        done_rx,
   output logic        rx_err,
   input  logic [31:0] data_tx,
   input  logic        flag_tx,
   output logic        done_tx
);

   localparam int CW      = $clog2(c_CLKS_PER_BIT);
   localparam int GAP_CYC = c_GAP_BITS * c_CLKS_PER_BIT;
   localparam int GW      = $clog2(GAP_CYC);
   localparam logic [CW-1:0] BIT_LAST  = CW'(c_CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(c_CLKS_PER_BIT / 2 - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

   // ---------------------------------------------------------------- RX
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t         rx_state, rx_state_n;
   logic              rx_meta, rx_sync;
   logic [CW-1:0]     rx_timer;
   logic [2:0]        rx_bit;
   logic [7:0]        rx_shift;
   logic [2:0]        rx_cnt;
   logic [1:0]        ctrl_buf;
   logic [23:0]       word_buf;
   logic [GW-1:0]     gap_cnt;
   logic              rx_tick, rx_half, stop_sample;

   assign rx_tick     = (rx_timer == BIT_LAST);
   assign rx_half     = (rx_timer == HALF_LAST);
   assign stop_sample = (rx_state == RX_STOP) && rx_tick;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rx_state <= RX_IDLE;
      else        rx_state <= rx_state_n;
   end

   always_comb begin
      rx_state_n = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_sync) rx_state_n = RX_START;
         // Line high again at the half-bit point means the start was a glitch.
         RX_START: if (rx_half) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_n = RX_STOP;
         RX_STOP:  if (rx_tick) rx_state_n = RX_IDLE;
         default:  rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         rx_timer    <= '0;
         rx_bit      <= '0;
         rx_shift    <= '0;
         rx_cnt      <= '0;
         ctrl_buf    <= '0;
         word_buf    <= '0;
         gap_cnt     <= '0;
         data_rx     <= '0;
         controlBits <= '0;
         done_rx     <= 1'b0;
         rx_err      <= 1'b0;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
         done_rx <= 1'b0;
         rx_err  <= 1'b0;

         case (rx_state)
            RX_IDLE:  begin rx_timer <= '0; rx_bit <= '0; end
            RX_START: rx_timer <= rx_half ? '0 : rx_timer + 1'b1;
            default:  rx_timer <= rx_tick ? '0 : rx_timer + 1'b1;
         endcase

         if (rx_state == RX_DATA && rx_tick) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
         end

         if (stop_sample) begin
            if (!rx_sync) begin
               rx_err <= 1'b1;
               rx_cnt <= '0;
            end else if (rx_cnt == 3'd0) begin
               ctrl_buf <= rx_shift[1:0];
               rx_cnt   <= 3'd1;
            end else if (rx_cnt == 3'd4) begin
               data_rx     <= {rx_shift, word_buf};
               controlBits <= ctrl_buf;
               done_rx     <= 1'b1;
               rx_cnt      <= '0;
            end else begin
               // Data bytes enter at the top so byte 1 ends up in bits [7:0].
               word_buf <= {rx_shift, word_buf[23:8]};
               rx_cnt   <= rx_cnt + 1'b1;
            end
         end

         // Inter-byte idle watchdog; only meaningful inside a partial frame.
         if (rx_state == RX_IDLE && rx_cnt != 3'd0) begin
            if (gap_cnt == GAP_LAST) begin
               rx_err  <= 1'b1;
               rx_cnt  <= '0;
               gap_cnt <= '0;
            end else begin
               gap_cnt <= gap_cnt + 1'b1;
            end
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------- TX
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

   tx_state_t         tx_state, tx_state_n;
   logic              flag_prev, tx_armed, tx_go;
   logic [31:0]       tx_word;
   logic [7:0]        tx_byte;
   logic [CW-1:0]     tx_timer;
   logic [2:0]        tx_bit;
   logic [1:0]        tx_idx;
   logic              tx_tick, tx_line_n, done_tx_n;

   // tx_armed blocks a flag_tx held high across reset from looking like an edge.
   assign tx_go   = flag_tx & ~flag_prev & tx_armed;
   assign tx_tick = (tx_timer == BIT_LAST);
   assign tx_byte = tx_word[{tx_idx, 3'b000} +: 8];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) tx_state <= TX_IDLE;
      else        tx_state <= tx_state_n;
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_line_n  = 1'b1;
      done_tx_n  = 1'b0;
      case (tx_state)
         TX_IDLE: if (tx_go) begin
            tx_state_n = TX_START;
            tx_line_n  = 1'b0;
         end
         TX_START: if (tx_tick) begin
            tx_state_n = TX_DATA;
            tx_line_n  = tx_byte[0];
         end else begin
            tx_line_n  = 1'b0;
         end
         TX_DATA: if (tx_tick) begin
            if (tx_bit == 3'd7) tx_state_n = TX_STOP;
            else                tx_line_n  = tx_byte[tx_bit + 3'd1];
         end else begin
            tx_line_n = tx_byte[tx_bit];
         end
         TX_STOP: if (tx_tick) begin
            if (tx_idx == 2'd3) begin
               tx_state_n = TX_DONE;
               done_tx_n  = 1'b1;
            end else begin
               tx_state_n = TX_START;
               tx_line_n  = 1'b0;
            end
         end
         TX_DONE: tx_state_n = TX_IDLE;
         default: tx_state_n = TX_IDLE;
      endcase
   end

   // TX is registered from the next-state decode so the pin never glitches.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         TX        <= 1'b1;
         done_tx   <= 1'b0;
         flag_prev <= 1'b0;
         tx_armed  <= 1'b0;
         tx_word   <= '0;
         tx_timer  <= '0;
         tx_bit    <= '0;
         tx_idx    <= '0;
      end else begin
         TX        <= tx_line_n;
         done_tx   <= done_tx_n;
         flag_prev <= flag_tx;
         tx_armed  <= tx_armed | ~flag_tx;
         case (tx_state)
            TX_IDLE: begin
               tx_timer <= '0;
               tx_bit   <= '0;
               tx_idx   <= '0;
               if (tx_go) tx_word <= data_tx;
            end
            TX_DONE: tx_timer <= '0;
            default: begin
               tx_timer <= tx_tick ? '0 : tx_timer + 1'b1;
               if (tx_tick && tx_state == TX_DATA) tx_bit <= tx_bit + 1'b1;
               if (tx_tick && tx_state == TX_STOP) tx_idx <= tx_idx + 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_word_serdes.sv
// tb/tb_uart_word_serdes.sv - self-checking bench for uart_word_serdes
module tb_uart_word_serdes;

   localparam int CPB = 8;
   localparam int GAP = 20;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        RX = 1'b1;
   logic        TX;
   logic [31:0] data_rx;
   logic [1:0]  controlBits;
   logic        done_rx;
   logic        rx_err;
   logic [31:0] data_tx = '0;
   logic        flag_tx = 1'b0;
   logic        done_tx;

   uart_word_serdes #(.c_CLKS_PER_BIT(CPB), .c_GAP_BITS(GAP)) dut (
      .CLK(CLK), .RST_N(RST_N), .RX(RX), .TX(TX),
      .data_rx(data_rx), .controlBits(controlBits),
      .done_rx(done_rx), .rx_err(rx_err),
      .data_tx(data_tx), .flag_tx(flag_tx), .done_tx(done_tx)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ------------------------------------------------------ reference model
   typedef struct {
      bit          is_err;
      logic [31:0] data;
      logic [1:0]  ctrl;
      int          t0;
   } rx_ev_t;

   rx_ev_t      exp_q[$];
   logic [31:0] exp_data = '0;
   logic [1:0]  exp_ctrl = '0;
   int          m_cnt = 0;
   logic [31:0] m_word = '0;
   logic [1:0]  m_ctrl = '0;
   int          done_tx_seen = 0;

   // Called as the stop bit goes onto the pin: decides what the frame yields.
   task automatic model_byte(input logic [7:0] b, input bit ok, input int t);
      if (!ok) begin
         exp_q.push_back('{is_err: 1'b1, data: 32'h0, ctrl: 2'b0, t0: t});
         m_cnt = 0;
      end else if (m_cnt == 0) begin
         m_ctrl = b[1:0];
         m_cnt  = 1;
      end else begin
         m_word[8*(m_cnt-1) +: 8] = b;
         m_cnt++;
         if (m_cnt == 5) begin
            exp_q.push_back('{is_err: 1'b0, data: m_word, ctrl: m_ctrl, t0: t});
            m_cnt = 0;
         end
      end
   endtask

   rx_ev_t cmp_ev;
   int     cmp_lat;

   always @(negedge CLK) begin
      if (!RST_N) begin
         exp_data = '0;
         exp_ctrl = '0;
      end else begin
         if (done_rx || rx_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rx_strobe", {30'b0, done_rx, rx_err}, 32'h0);
            end else begin
               cmp_ev = exp_q.pop_front();
               chk("rx_strobe_kind", {30'b0, done_rx, rx_err}, cmp_ev.is_err ? 32'h1 : 32'h2);
               if (!cmp_ev.is_err) begin
                  chk("done_rx_data", data_rx, cmp_ev.data);
                  chk("done_rx_ctrl", {30'b0, controlBits}, {30'b0, cmp_ev.ctrl});
                  cmp_lat = cyc - cmp_ev.t0;
                  chk("done_rx_latency", 32'(cmp_lat >= CPB/2 + 2 && cmp_lat <= CPB/2 + 4), 32'h1);
                  exp_data = cmp_ev.data;
                  exp_ctrl = cmp_ev.ctrl;
               end
            end
         end else begin
            chk("data_rx_held", data_rx, exp_data);
            chk("ctrl_held", {30'b0, controlBits}, {30'b0, exp_ctrl});
         end
         if (done_tx) done_tx_seen++;
      end
   end

   // ------------------------------------------------------ RX stimulus
   task automatic drive_bits(input logic v, input int n);
      RX = v;
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      drive_bits(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
      model_byte(b, ok, cyc);
      drive_bits(ok, CPB);
      if (!ok) drive_bits(1'b1, 2*CPB);
   endtask

   task automatic send_frame(input logic [39:0] f);
      for (int i = 0; i < 5; i++) send_byte(f[8*i +: 8], 1'b1);
   endtask

   task automatic rx_idle(input int nbits);
      if (nbits > GAP && m_cnt != 0) begin
         exp_q.push_back('{is_err: 1'b1, data: 32'h0, ctrl: 2'b0, t0: cyc});
         m_cnt = 0;
      end
      drive_bits(1'b1, nbits*CPB);
   endtask

   // ------------------------------------------------------ TX capture
   task automatic tx_send(input logic [31:0] w, input bit hold, output logic [31:0] got);
      int n;
      int t_low;
      int d0;
      bit stray;
      logic [7:0] b;
      got = '0;
      b = '0;
      data_tx = w;
      d0 = done_tx_seen;
      flag_tx = 1'b1;
      n = 0;
      while (TX !== 1'b0 && n < 10) begin
         @(negedge CLK);
         n++;
      end
      chk("tx_start_latency", 32'(n >= 1 && n <= 3), 32'h1);
      if (TX !== 1'b0) begin
         flag_tx = 1'b0;
         @(negedge CLK);
         return;
      end
      t_low = cyc;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 10; j++) begin
            repeat (CPB/2) @(negedge CLK);
            if (j == 0)      chk("tx_start_bit", {31'b0, TX}, 32'h0);
            else if (j == 9) chk("tx_stop_bit", {31'b0, TX}, 32'h1);
            else             b[j-1] = TX;
            repeat (CPB/2) @(negedge CLK);
         end
         chk("tx_byte", {24'b0, b}, (w >> (8*k)) & 32'hFF);
         got[8*k +: 8] = b;
      end
      chk("tx_word_cycles", cyc - t_low, 32'd320);
      chk("done_tx_high", {31'b0, done_tx}, 32'h1);
      @(negedge CLK);
      chk("done_tx_one_cycle", {31'b0, done_tx}, 32'h0);
      if (hold) begin
         stray = 1'b0;
         repeat (6*CPB) begin
            @(negedge CLK);
            if (TX !== 1'b1 || done_tx !== 1'b0) stray = 1'b1;
         end
         chk("tx_no_resend_while_high", {31'b0, stray}, 32'h0);
      end
      chk("done_tx_count", done_tx_seen - d0, 32'h1);
      flag_tx = 1'b0;
      @(negedge CLK);
   endtask

   // ------------------------------------------------------ sequence
   logic [31:0] got;
   logic [31:0] got2;
   bit          stray;
   int          d0;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("rst_TX", {31'b0, TX}, 32'h1);
      chk("rst_data_rx", data_rx, 32'h0);
      chk("rst_controlBits", {30'b0, controlBits}, 32'h0);
      chk("rst_done_rx", {31'b0, done_rx}, 32'h0);
      chk("rst_rx_err", {31'b0, rx_err}, 32'h0);
      chk("rst_done_tx", {31'b0, done_tx}, 32'h0);
      repeat (2) @(negedge CLK);

      // Directed RX frame
      send_frame(40'hDE_AD_BE_EF_02);
      rx_idle(2);
      chk("frame1_data", data_rx, 32'hDEADBEEF);
      chk("frame1_ctrl", {30'b0, controlBits}, 32'h2);
      chk("frame1_events", exp_q.size(), 32'h0);

      // Directed TX word with flag held high afterwards
      tx_send(32'h12345678, 1'b1, got);
      chk("tx1_word", got, 32'h12345678);

      // Framing error on byte 2, then a good frame
      send_byte(8'h03, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b0);
      rx_idle(2);
      chk("framing_data_kept", data_rx, 32'hDEADBEEF);
      send_frame(40'h44_33_22_11_01);
      rx_idle(2);
      chk("frame2_data", data_rx, 32'h44332211);
      chk("frame2_ctrl", {30'b0, controlBits}, 32'h1);

      // Gap timeout after two bytes
      send_byte(8'h01, 1'b1);
      send_byte(8'h99, 1'b1);
      rx_idle(GAP + 1);
      chk("gap_events", exp_q.size(), 32'h0);
      chk("gap_data_kept", data_rx, 32'h44332211);

      // Short glitch on idle line
      RX = 1'b0;
      repeat (3) @(negedge CLK);
      rx_idle(3);
      chk("glitch_events", exp_q.size(), 32'h0);

      // Full duplex
      fork
         tx_send(32'hA5A5A5A5, 1'b0, got2);
         send_frame(40'h00_00_00_01_00);
      join
      rx_idle(2);
      chk("duplex_data", data_rx, 32'h00000001);
      chk("duplex_ctrl", {30'b0, controlBits}, 32'h0);
      chk("duplex_tx", got2, 32'hA5A5A5A5);

      // Random RX bytes, occasional bad stop bits
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 5; i++) begin
            send_byte(8'($urandom), $urandom_range(0, 7) != 0);
            rx_idle($urandom_range(0, 2));
         end
      end
      rx_idle(2);
      if (m_cnt != 0) rx_idle(GAP + 2);
      chk("random_rx_events", exp_q.size(), 32'h0);

      // Random TX words
      for (int i = 0; i < 4; i++) begin
         tx_send($urandom, bit'($urandom_range(0, 1)), got);
      end

      // Reset in the middle of a transmission
      data_tx = $urandom;
      flag_tx = 1'b1;
      repeat (20) @(negedge CLK);
      #2;
      RST_N = 1'b0;
      m_cnt = 0;
      #1;
      chk("midrst_TX", {31'b0, TX}, 32'h1);
      chk("midrst_data_rx", data_rx, 32'h0);
      chk("midrst_controlBits", {30'b0, controlBits}, 32'h0);
      chk("midrst_done_rx", {31'b0, done_rx}, 32'h0);
      chk("midrst_rx_err", {31'b0, rx_err}, 32'h0);
      chk("midrst_done_tx", {31'b0, done_tx}, 32'h0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      d0 = done_tx_seen;
      stray = 1'b0;
      repeat (8*CPB) begin
         @(negedge CLK);
         if (TX !== 1'b1) stray = 1'b1;
      end
      chk("postrst_no_send", {31'b0, stray}, 32'h0);
      chk("postrst_no_done", done_tx_seen - d0, 32'h0);
      flag_tx = 1'b0;
      @(negedge CLK);
      tx_send(32'hC001D00D, 1'b0, got);
      chk("postrst_tx", got, 32'hC001D00D);

      repeat (2*CPB) @(negedge CLK);
      chk("final_events", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_word_serdes.md
# uart_word_serdes

Full-duplex 8N1 UART that carries 32-bit words plus a 2-bit register selector, sitting directly below the UART-to-Avalon bridge. It deserialises 5-byte frames from RX into `data_rx`/`controlBits` with a one-cycle `done_rx` strobe. It serialises a 32-bit `data_tx` word onto TX as 4 bytes when the bridge raises `flag_tx`, then pulses `done_tx`.

## Interface
- `c_CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `c_GAP_BITS`, 20: maximum idle bit-periods allowed between bytes of one RX frame.
- `CLK`  in  1  single system clock; all logic on its rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `RX`  in  1  serial input, asynchronous to CLK, idle high.
- `TX`  out  1  serial output, idle high.
- `data_rx`  out  32  last received word; held until the next good frame.
- `controlBits`  out  2  selector from the last received frame; held like `data_rx`.
- `done_rx`  out  1  one-cycle strobe: `data_rx`/`controlBits` updated this cycle.
- `rx_err`  out  1  one-cycle strobe: frame discarded (framing error or gap timeout).
- `data_tx`  in  32  word to transmit; sampled on the `flag_tx` rising edge.
- `flag_tx`  in  1  transmit request level; a send starts on its rising edge only.
- `done_tx`  out  1  one-cycle strobe after the last stop bit of a word.

## Operation
- RX path:
  - `RX` passes through a 2-flop synchronizer.
  - A falling edge while RX is idle starts a byte. The line is resampled at `c_CLKS_PER_BIT/2`; if it is high there, the start is a glitch and RX returns to idle without an error.
  - The 8 data bits, LSB first, are sampled one bit-period apart at mid-bit. The stop bit is sampled the same way.
- RX frame:
  - Byte 0 = control; bits[1:0] become `controlBits` and bits[7:2] are ignored.
  - Bytes 1–4 = data, least-significant byte first.
  - After byte 4's stop bit, `data_rx` and `controlBits` update and `done_rx` pulses in the same cycle.
- RX errors:
  - A stop bit sampled low raises `rx_err` for one cycle, discards the partial frame, and resets the byte counter to 0.
  - A gap counter runs while 1 ≤ byte count ≤ 4 and RX is idle. After `c_GAP_BITS × c_CLKS_PER_BIT` cycles it discards the partial frame and pulses `rx_err`.
- RX state machine: RX_IDLE → RX_START → RX_DATA (8 bits) → RX_STOP → RX_IDLE. RX_START returns to RX_IDLE on a glitch.
- TX path:
  - Rising-edge detect on `flag_tx`, using a registered previous value. An edge while TX is busy is ignored and not queued.
  - On an accepted edge, `data_tx` is latched. Bytes 0–3 are sent LSB-byte first, each as start(0), 8 data bits LSB first, stop(1).
  - Bytes are sent back-to-back with no idle bits between them.
- TX state machine: TX_IDLE → TX_START → TX_DATA → TX_STOP. TX_STOP returns to TX_START for the next byte, or goes to TX_DONE after byte 3. TX_DONE pulses `done_tx` for one cycle, then enters TX_IDLE.
- Keeping `flag_tx` high through and after `done_tx` never starts a second send; it must go low and then high again.
- RX and TX are fully independent; simultaneous activity is legal.
- Counters:
  - Bit-timer width is `$clog2(c_CLKS_PER_BIT)`; it wraps to 0 at `c_CLKS_PER_BIT-1`.
  - The RX byte counter is 3 bits (0–4). The TX byte counter is 2 bits.

## Timing
- Reset values: `TX`=1, `data_rx`=0, `controlBits`=0, `done_rx`=0, `rx_err`=0, `done_tx`=0.
- Reset state: both FSMs idle, all counters 0, edge-detect register 0.
- Reset asserted mid-frame:
  - `TX` goes to 1 asynchronously and any partial RX frame is lost.
  - After release, a `flag_tx` that is already high does not start a send.
- TX timing:
  - The start bit drives `TX`=0 on the cycle after the cycle in which the `flag_tx` rising edge is registered.
  - Each bit lasts exactly `c_CLKS_PER_BIT` cycles; one word = 40 bit-periods.
  - `done_tx` is high in the cycle after byte 3's stop bit completes.
- RX timing:
  - Mid-bit sampling occurs 2 cycles late due to the synchronizer.
  - `done_rx` asserts `c_CLKS_PER_BIT/2 + 3` cycles (±1) after the last stop bit's leading edge on the pin.
  - `done_rx` and `rx_err` are mutually exclusive.
  - A new start bit is accepted immediately after the stop-bit sample.

## Test plan
- Use `c_CLKS_PER_BIT`=8 throughout.
- RX frame: drive bytes 0x02,0xEF,0xBE,0xAD,0xDE → one `done_rx` pulse, `data_rx`=0xDEADBEEF, `controlBits`=2'b10, `rx_err` stays 0.
- TX word: `data_tx`=0x12345678, raise `flag_tx` and hold it high → TX shows bytes 0x78,0x56,0x34,0x12, 320 cycles total. `done_tx` pulses once; no second word while `flag_tx` stays high.
- Framing error: byte 2 with stop bit forced low → one `rx_err` pulse, no `done_rx`, `data_rx` unchanged. A following good frame 0x01,0x11,0x22,0x33,0x44 gives `data_rx`=0x44332211, `controlBits`=01.
- Gap timeout and glitch: send 2 bytes, then idle 21 bit-periods → `rx_err` pulse. A 3-cycle low glitch on idle RX produces no pulses.
- Duplex and reset: TX 0xA5A5A5A5 concurrent with RX frame 0x00,0x01,0x00,0x00,0x00 → `done_rx` with `data_rx`=1 and `done_tx` both occur. A second TX started and then `RST_N`=0 mid-byte → `TX`=1 immediately; all outputs at reset values.
